// File: rtl/up_down_count_pkg.sv
// Shared definitions for the up/down counter observation blocks.
//   mon_state_e : monitor state encoding (ACQUIRE, TRACK, FAULT)
//   COUNT_W     : default count bus width
//   STAT_W      : default statistics counter width
package up_down_count_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        FAULT   = 2'd2
    } mon_state_e;

    localparam int COUNT_W = 4;
    localparam int STAT_W  = 16;

endpackage

// File: rtl/up_down_count_monitor_sat_counter.sv
// Saturating incrementer used for the monitor's step statistics.
// Ports:
//   clk   in  : clock, rising edge
//   rst_n in  : synchronous active-low reset
//   clear in  : synchronous soft clear, same effect as reset
//   inc   in  : add one this cycle unless already at all-ones
//   count out : CNT_W-bit count, holds at 2^CNT_W-1
module sat_counter
    import up_down_count_pkg::*;
#(
    parameter int CNT_W = STAT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/up_down_count_monitor.sv
// Receive-side checker for an up/down counter's count bus. Recovers the
// commanded direction from consecutive samples, flags illegal steps,
// recognises jumps to zero as counter resets and keeps up/down statistics.
// Ports:
//   clk          in  : clock, rising edge
//   rst_n        in  : synchronous active-low reset
//   clear        in  : synchronous soft clear, same effect as reset
//   sample_valid in  : sample carries a valid observation this cycle
//   sample       in  : observed count value
//   dir_valid    out : pulse, legal unit step decoded
//   dir_up       out : direction of last legal step (1 = up), held
//   resync       out : pulse, jump to zero accepted as counter reset
//   step_err     out : pulse, illegal step detected
//   locked       out : high while tracking
//   fault        out : high while faulted
//   up_cnt       out : saturating count of legal up steps
//   down_cnt     out : saturating count of legal down steps
//
// state   | meaning
// ACQUIRE | no reference sample held
// TRACK   | reference held, steps being decoded
// FAULT   | ERR_LIMIT consecutive illegal steps; frozen until clear/reset
module up_down_count_monitor
    import up_down_count_pkg::*;
#(
    parameter int WIDTH     = COUNT_W,
    parameter int CNT_W     = STAT_W,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             dir_valid,
    output logic             dir_up,
    output logic             resync,
    output logic             step_err,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] up_cnt,
    output logic [CNT_W-1:0] down_cnt
);

    localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1);
    localparam logic [3:0]       ERR_LIM  = 4'(ERR_LIMIT);

    mon_state_e       state;
    logic [WIDTH-1:0] prev;
    logic [3:0]       err_run;
    logic [WIDTH-1:0] delta;
    logic [3:0]       err_next;
    logic             track_hit;
    logic             is_up;
    logic             is_down;

    // Modulo-2^WIDTH difference makes wrap-around a plain unit step.
    assign delta     = sample - prev;
    assign err_next  = err_run + 4'd1;
    assign track_hit = sample_valid && (state == TRACK);
    assign is_up     = (delta == STEP_ONE);
    assign is_down   = (delta == '1);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state     <= ACQUIRE;
            prev      <= '0;
            err_run   <= '0;
            dir_valid <= 1'b0;
            dir_up    <= 1'b0;
            resync    <= 1'b0;
            step_err  <= 1'b0;
            locked    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            dir_valid <= 1'b0;
            resync    <= 1'b0;
            step_err  <= 1'b0;
            if (sample_valid) begin
                case (state)
                    ACQUIRE: begin
                        prev   <= sample;
                        state  <= TRACK;
                        locked <= 1'b1;
                    end
                    TRACK: begin
                        prev <= sample;
                        if (is_up) begin
                            dir_valid <= 1'b1;
                            dir_up    <= 1'b1;
                            err_run   <= '0;
                        end else if (is_down) begin
                            dir_valid <= 1'b1;
                            dir_up    <= 1'b0;
                            err_run   <= '0;
                        end else if (sample == '0) begin
                            resync  <= 1'b1;
                            err_run <= '0;
                        end else begin
                            step_err <= 1'b1;
                            err_run  <= err_next;
                            if (err_next == ERR_LIM) begin
                                state  <= FAULT;
                                locked <= 1'b0;
                                fault  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        // FAULT: samples ignored until clear or reset
                    end
                endcase
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_up_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (track_hit && is_up),
        .count (up_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_down_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (track_hit && is_down),
        .count (down_cnt)
    );

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Bench for up_down_count_monitor: directed scenarios followed by random
// samples, every cycle compared against a behavioural model of the rules.
module tb_up_down_count_monitor;
    import up_down_count_pkg::*;

    localparam int W   = COUNT_W;
    localparam int CW  = 4;
    localparam int LIM = 3;
    localparam int MOD = 1 << W;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          sample_valid = 1'b0;
    logic [W-1:0]  sample = '0;
    logic          dir_valid, dir_up, resync, step_err, locked, fault;
    logic [CW-1:0] up_cnt, down_cnt;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 = no reference, 1 = tracking, 2 = faulted
    int m_mode = 0, m_prev = 0, m_err = 0;
    int m_dv = 0, m_up = 0, m_rs = 0, m_se = 0, m_upc = 0, m_dnc = 0;

    up_down_count_monitor #(.WIDTH(W), .CNT_W(CW), .ERR_LIMIT(LIM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample       (sample),
        .dir_valid    (dir_valid),
        .dir_up       (dir_up),
        .resync       (resync),
        .step_err     (step_err),
        .locked       (locked),
        .fault        (fault),
        .up_cnt       (up_cnt),
        .down_cnt     (down_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int v, input int s, input int clr, input int rn);
        int d;
        if (rn == 0 || clr != 0) begin
            m_mode = 0; m_prev = 0; m_err = 0;
            m_dv = 0; m_up = 0; m_rs = 0; m_se = 0; m_upc = 0; m_dnc = 0;
            return;
        end
        m_dv = 0; m_rs = 0; m_se = 0;
        if (v == 0) return;
        if (m_mode == 0) begin
            m_prev = s;
            m_mode = 1;
        end else if (m_mode == 1) begin
            d = (s - m_prev + MOD) % MOD;
            m_prev = s;
            if (d == 1) begin
                m_dv = 1; m_up = 1; m_err = 0;
                if (m_upc < SAT) m_upc++;
            end else if (d == MOD - 1) begin
                m_dv = 1; m_up = 0; m_err = 0;
                if (m_dnc < SAT) m_dnc++;
            end else if (s == 0) begin
                m_rs = 1; m_err = 0;
            end else begin
                m_se = 1; m_err++;
                if (m_err == LIM) m_mode = 2;
            end
        end
    endtask

    task automatic step(input int v, input int s, input int clr, input int rn);
        sample_valid = v[0];
        sample       = W'(s);
        clear        = clr[0];
        rst_n        = rn[0];
        @(posedge clk);
        #1;
        model(v, s, clr, rn);
        check("dir_valid", 32'(dir_valid), 32'(m_dv));
        check("dir_up",    32'(dir_up),    32'(m_up));
        check("resync",    32'(resync),    32'(m_rs));
        check("step_err",  32'(step_err),  32'(m_se));
        check("locked",    32'(locked),    32'(m_mode == 1));
        check("fault",     32'(fault),     32'(m_mode == 2));
        check("up_cnt",    32'(up_cnt),    32'(m_upc));
        check("down_cnt",  32'(down_cnt),  32'(m_dnc));
    endtask

    task automatic samp(input int s);
        step(1, s, 0, 1);
    endtask

    task automatic do_clear();
        step(1, 3, 1, 1);
    endtask

    initial begin
        int r, k, s;
        step(0, 0, 0, 0);
        step(1, 5, 0, 0);
        check("reset_locked", 32'(locked), 32'd0);

        // Counting up from 5
        samp(5);
        check("acq_locked", 32'(locked), 32'd1);
        check("acq_no_pulse", 32'(dir_valid), 32'd0);
        samp(6); samp(7); samp(8);
        check("plan1_up_cnt", 32'(up_cnt), 32'd3);
        check("plan1_down_cnt", 32'(down_cnt), 32'd0);

        // Down across the wrap, then up across it
        do_clear();
        samp(1); samp(0); samp(15); samp(14);
        check("plan2_down_cnt", 32'(down_cnt), 32'd3);
        samp(15); samp(0);
        check("plan2_up_cnt", 32'(up_cnt), 32'd2);

        // Jump to zero is a resync
        do_clear();
        samp(9); samp(0);
        check("plan3_resync", 32'(resync), 32'd1);
        samp(1);
        check("plan3_dir_up", 32'(dir_up), 32'd1);

        // Three illegal steps fault
        do_clear();
        samp(3); samp(7); samp(7); samp(12);
        check("plan4_fault", 32'(fault), 32'd1);
        samp(13); samp(14);
        step(0, 0, 0, 1);
        do_clear();
        check("plan4_clear_fault", 32'(fault), 32'd0);

        // Legal step clears the error run
        samp(2); samp(9); samp(10); samp(3); samp(8);
        check("plan5_no_fault", 32'(fault), 32'd0);
        check("plan5_locked", 32'(locked), 32'd1);

        // Saturation of the up counter, then reset mid-stream
        do_clear();
        samp(0);
        for (int i = 1; i <= 20; i++) samp(i % MOD);
        check("sat_up_cnt", 32'(up_cnt), 32'(SAT));
        step(1, 5, 0, 0);
        check("midrst_up_cnt", 32'(up_cnt), 32'd0);
        samp(6);
        check("reacq_no_pulse", 32'(dir_valid), 32'd0);

        // Random stream biased toward legal steps
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            k = int'($urandom_range(0, 5));
            case (k)
                0, 1:    s = (m_prev + 1) % MOD;
                2:       s = (m_prev + MOD - 1) % MOD;
                3:       s = 0;
                4:       s = int'($urandom_range(0, MOD - 1));
                default: s = m_prev;
            endcase
            step(r < 80 ? 1 : 0, s, r >= 97 ? 1 : 0, r == 96 ? 0 : 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/up_down_count_monitor.md
# up_down_count_monitor

Receive-side checker for the up/down counter's 4-bit count bus. It samples the count value each cycle `sample_valid` is high and recovers the commanded direction from consecutive samples. It flags illegal steps, recognises counter resets, and keeps saturating up/down step statistics. It sits on the observation side of any counter instance and lets a scoreboard or a status register read back what the counter was told to do.

## Interface
- `WIDTH`, 4: count bus width; legal range 2..16.
- `CNT_W`, 16: width of the statistics counters.
- `ERR_LIMIT`, 3: consecutive illegal steps that force FAULT; legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `clear`  in  1  synchronous soft clear; same effect as reset.
- `sample_valid`  in  1  `sample` is a valid count observation this cycle.
- `sample`  in  WIDTH  observed count value.
- `dir_valid`  out  1  one-cycle pulse: a legal unit step was decoded.
- `dir_up`  out  1  direction of the last legal step; 1 = up. Held between pulses.
- `resync`  out  1  one-cycle pulse: a jump to 0 was accepted as a counter reset.
- `step_err`  out  1  one-cycle pulse: an illegal step was detected.
- `locked`  out  1  high while in TRACK.
- `fault`  out  1  high while in FAULT.
- `up_cnt`  out  CNT_W  saturating count of legal up steps.
- `down_cnt`  out  CNT_W  saturating count of legal down steps.

## Operation
- States:
  - ACQUIRE: no reference sample is held.
  - TRACK: a reference sample is held and steps are being decoded.
  - FAULT: too many consecutive illegal steps; decoding is stopped.
- Reset or `clear`:
  - state → ACQUIRE.
  - All outputs → 0: `dir_valid`, `dir_up`, `resync`, `step_err`, `locked`, `fault`, `up_cnt`, `down_cnt`.
  - `prev` and the error run counter `err_run` → 0.
  - `clear` has priority over `sample_valid` in the same cycle.
- ACQUIRE, on a valid sample: store it in `prev` → TRACK. No pulses are emitted.
- TRACK, on a valid sample: compute `delta = sample - prev` modulo 2^WIDTH. Always store `prev <= sample`. Evaluate in this priority order:
  1. `delta == 1`: up step. Pulse `dir_valid`, set `dir_up=1`, increment `up_cnt`, clear `err_run`.
  2. `delta == all-ones`: down step. Pulse `dir_valid`, set `dir_up=0`, increment `down_cnt`, clear `err_run`.
  3. `sample == 0`, otherwise: counter reset. Pulse `resync`, clear `err_run`; `dir_up` is unchanged.
  4. Anything else, including `delta == 0`: illegal step. Pulse `step_err`, increment `err_run`. When `err_run` reaches ERR_LIMIT → FAULT.
- Wrap-around is a legal unit step: all-ones→0 is up, 0→all-ones is down. The unit-step rules take priority over rule 3.
- FAULT:
  - Samples are ignored; `prev`, the statistics counters and `dir_up` are frozen.
  - No pulses are emitted.
  - Exit only via `clear` or reset.
- `up_cnt` and `down_cnt` saturate at 2^CNT_W−1 and never wrap.
- When `sample_valid` is low, no state changes and no pulses occur.

## Timing
- All outputs are registered.
- A sample accepted at edge N produces its pulse and counter update visible after edge N (1-cycle latency).
- Pulses last exactly one cycle. Back-to-back valid samples give back-to-back pulses.
- `locked` rises in the cycle after the first valid sample in ACQUIRE.
- `fault` and `locked=0` appear together with the `step_err` pulse that reaches ERR_LIMIT.
- Reset asserted mid-stream: the next edge gives the full reset state, and the first valid sample after release only re-acquires.

## Structure
- Shared package `up_down_count_pkg`:
  - State enum `mon_state_e` (ACQUIRE, TRACK, FAULT).
  - Default constants COUNT_W=4 and STAT_W=16, reused by the counter and by bench code.
- One sub-module, `sat_counter`: a CNT_W-bit saturating incrementer with synchronous active-low reset and clear. It is instantiated twice, for up and down.
- The FSM, delta compute and pulse logic stay in the top module.

## Test plan
- Reset, then samples 5,6,7,8 → first sample gives `locked=1` with no pulse. Then three `dir_valid` pulses with `dir_up=1`; `up_cnt=3`, `down_cnt=0`.
- Samples 1,0,15,14 then 14,15,0 → down steps across the wrap (`down_cnt=3`), then up steps across the wrap. Total `up_cnt=2`, `step_err` never pulses.
- Samples 9,0,1 → `resync` pulses on 0 with no `step_err`; then an up step with `dir_up=1`.
- With ERR_LIMIT=3, samples 3,7,7,12 → three `step_err` pulses; `fault=1` and `locked=0` on the third. Further samples are ignored. Pulsing `clear` returns to ACQUIRE with all outputs 0.
- Samples 2,9,10 → one `step_err`, then a legal up step clears `err_run`. Two more illegal steps do not fault (`err_run` reaches 2 only).
- Force `up_cnt` near saturation with CNT_W=4 and 20 consecutive up steps → `up_cnt` holds at 15. Assert `rst_n=0` mid-stream with `sample_valid=1` → all outputs 0 on the next edge.
